// File: rtl/mips_sim_pkg.sv
// Shared definitions for the MIPS simulation supervisor.
//   sim_status_e         verdict / FSM state encoding, also driven on the status port
//   BOOT_FAIL_CODE       fail_code reported when the first fetch misses the boot PC
//   *_ADDR_DEFAULT       default tohost / console store addresses, shared with mips_tb
//                        and the program loaders
package mips_sim_pkg;

    typedef enum logic [2:0] {
        StReset   = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4,
        StHang    = 3'd5
    } sim_status_e;

    localparam logic [31:0] BOOT_FAIL_CODE       = 32'hB007_0BAD;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT  = 32'hFFFF_FFF0;
    localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'hFFFF_FFF4;

    function automatic logic is_terminal(input sim_status_e s);
        return (s == StPass) || (s == StFail) || (s == StTimeout) || (s == StHang);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst   clock and asynchronous active-high reset (count -> 0)
//   clr        synchronous clear, wins over inc
//   inc        add one; holds at all-ones instead of wrapping
//   count      current value
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_sim_supervisor.sv
// Simulation supervisor for mips_cpu_adv + Memory.
// Releases the CPU reset RESET_CYCLES clocks after rst falls, checks the boot fetch, decodes
// tohost / console stores, runs cycle and stall watchdogs and holds a sticky verdict.
//   clk, rst                 clock, asynchronous active-high reset
//   inst_addr, data_addr     CPU fetch and data addresses
//   data_in, mem_write       CPU store data and strobe
//   cpu_rst                  reset to CPU/memory (async assert, sync release)
//   running, done, pass      RUN / any terminal state / PASS
//   status                   sim_status_e encoding of the current state
//   fail_code                failing tohost value or BOOT_FAIL_CODE
//   console_valid/_byte      one-cycle pulse per console store, byte held until the next
//   cycle_count, store_count saturating RUN-cycle and accepted-store counts
module mips_sim_supervisor
    import mips_sim_pkg::*;
#(
    parameter int unsigned        ADDR_W       = 32,
    parameter int unsigned        DATA_W       = 32,
    parameter int unsigned        RESET_CYCLES = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC     = ADDR_W'(32'h1000),
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR  = ADDR_W'(TOHOST_ADDR_DEFAULT),
    parameter logic [ADDR_W-1:0]  CONSOLE_ADDR = ADDR_W'(CONSOLE_ADDR_DEFAULT),
    parameter logic [DATA_W-1:0]  PASS_CODE    = DATA_W'(32'h1),
    parameter int unsigned        MAX_CYCLES   = 100000,
    parameter int unsigned        STALL_LIMIT  = 1024,
    parameter int unsigned        CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mem_write,
    output logic              cpu_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic [2:0]        status,
    output logic [DATA_W-1:0] fail_code,
    output logic              console_valid,
    output logic [7:0]        console_byte,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count
);

    localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);

    sim_status_e       state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q;
    logic [ADDR_W-1:0] prev_addr_q;
    logic [DATA_W-1:0] fail_code_q;
    logic              console_valid_q;
    logic [7:0]        console_byte_q;
    logic [CNT_W-1:0]  stall_count;

    logic in_run, in_reset, first_cycle, boot_bad, tohost_wr, console_wr;
    logic same_pc, stall_hit, timeout_hit;

    assign in_run      = (state_q == StRun);
    assign in_reset    = (state_q == StReset);
    // cycle_count only sits at 0 during the first RUN cycle
    assign first_cycle = in_run && (cycle_count == '0);
    assign boot_bad    = first_cycle && (inst_addr != RESET_PC);
    assign tohost_wr   = in_run && mem_write && (data_addr == TOHOST_ADDR);
    assign console_wr  = in_run && mem_write && (data_addr == CONSOLE_ADDR);
    // prev_addr_q is loaded on every edge, so a fetch address held across the reset release
    // already counts as unchanged on the first RUN edge
    assign same_pc     = (inst_addr == prev_addr_q);
    assign stall_hit   = in_run && same_pc && (stall_count == CNT_W'(STALL_LIMIT - 1));
    assign timeout_hit = in_run && (cycle_count == CNT_W'(MAX_CYCLES - 1));

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_reset),
        .inc   (in_run),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_store_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_reset),
        .inc   (in_run && mem_write),
        .count (store_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_reset || !same_pc),
        .inc   (in_run),
        .count (stall_count)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; RUN exits are ordered boot check > tohost > HANG > TIMEOUT
    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: begin
                if (rst_cnt_q <= RC_W'(1)) state_d = StRun;
            end
            StRun: begin
                if (boot_bad) begin
                    state_d = StFail;
                end else if (tohost_wr) begin
                    state_d = (data_in == PASS_CODE) ? StPass : StFail;
                end else if (stall_hit) begin
                    state_d = StHang;
                end else if (timeout_hit) begin
                    state_d = StTimeout;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Reset sequencer, verdict payload and console capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt_q       <= RC_W'(RESET_CYCLES);
            prev_addr_q     <= '0;
            fail_code_q     <= '0;
            console_valid_q <= 1'b0;
            console_byte_q  <= '0;
        end else begin
            prev_addr_q     <= inst_addr;
            console_valid_q <= console_wr;
            if (in_reset && (rst_cnt_q != '0)) begin
                rst_cnt_q <= rst_cnt_q - 1'b1;
            end
            if (boot_bad) begin
                fail_code_q <= DATA_W'(BOOT_FAIL_CODE);
            end else if (tohost_wr && (data_in != PASS_CODE)) begin
                fail_code_q <= data_in;
            end
            if (console_wr) begin
                console_byte_q <= data_in[7:0];
            end
        end
    end

    // Outputs
    always_comb begin
        cpu_rst = in_reset;
        running = in_run;
        done    = is_terminal(state_q);
        pass    = (state_q == StPass);
        status  = state_q;
    end

    assign fail_code     = fail_code_q;
    assign console_valid = console_valid_q;
    assign console_byte  = console_byte_q;

endmodule

// File: tb/tb_mips_sim_supervisor.sv
// Directed bench for mips_sim_supervisor (RESET_CYCLES=2, MAX_CYCLES=50, STALL_LIMIT=8).
module tb_mips_sim_supervisor;

    localparam logic [31:0] TOHOST  = 32'hFFFF_FFF0;
    localparam logic [31:0] CONSOLE = 32'hFFFF_FFF4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr, data_addr, data_in;
    logic        mem_write;
    logic        cpu_rst, running, done, pass, console_valid;
    logic [2:0]  status;
    logic [31:0] fail_code, cycle_count, store_count;
    logic [7:0]  console_byte;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_sim_supervisor #(
        .RESET_CYCLES (2),
        .MAX_CYCLES   (50),
        .STALL_LIMIT  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_addr     (inst_addr),
        .data_addr     (data_addr),
        .data_in       (data_in),
        .mem_write     (mem_write),
        .cpu_rst       (cpu_rst),
        .running       (running),
        .done          (done),
        .pass          (pass),
        .status        (status),
        .fail_code     (fail_code),
        .console_valid (console_valid),
        .console_byte  (console_byte),
        .cycle_count   (cycle_count),
        .store_count   (store_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // n clock edges; the fetch address advances by 4 after each one
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            inst_addr = inst_addr + 32'd4;
        end
    endtask

    // n clock edges with the fetch address frozen
    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-edge store with the fetch address advancing
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        data_addr = addr;
        data_in   = data;
        mem_write = 1'b1;
        adv(1);
        mem_write = 1'b0;
        data_addr = '0;
        data_in   = '0;
    endtask

    // Pulse rst between edges and wait the two reset cycles; returns at the first RUN cycle
    task automatic restart(input logic [31:0] boot);
        rst       = 1'b1;
        mem_write = 1'b0;
        inst_addr = boot;
        #3;
        rst = 1'b0;
        hold(2);
    endtask

    initial begin
        rst       = 1'b1;
        inst_addr = 32'h1000;
        data_addr = TOHOST;
        data_in   = 32'h1;
        mem_write = 1'b1;   // tohost store during reset must be ignored
        #10;
        check_eq("rst_cpu_rst", cpu_rst, 1);
        check_eq("rst_status", status, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cycles", cycle_count, 0);
        #7;
        rst = 1'b0;
        #3;
        check_eq("rel_cpu_rst", cpu_rst, 1);
        check_eq("rel_running", running, 0);
        hold(1);
        check_eq("edge1_cpu_rst", cpu_rst, 1);
        check_eq("edge1_running", running, 0);
        hold(1);
        check_eq("edge2_cpu_rst", cpu_rst, 0);
        check_eq("edge2_running", running, 1);
        check_eq("edge2_status", status, 1);
        check_eq("reset_store_ignored", store_count, 0);
        mem_write = 1'b0;
        data_addr = '0;
        data_in   = '0;

        // Pass run
        adv(4);
        check_eq("pass_pre_status", status, 1);
        store(TOHOST, 32'h1);
        check_eq("pass_done", done, 1);
        check_eq("pass_pass", pass, 1);
        check_eq("pass_status", status, 2);
        check_eq("pass_stores", store_count, 1);
        check_eq("pass_cycles", cycle_count, 5);
        store(32'h2000, 32'h5);
        adv(2);
        check_eq("frozen_cycles", cycle_count, 5);
        check_eq("frozen_stores", store_count, 1);
        check_eq("frozen_status", status, 2);
        check_eq("frozen_cpu_rst", cpu_rst, 0);

        // Tohost fail code
        restart(32'h1000);
        check_eq("rerun_fail_code_clr", fail_code, 0);
        check_eq("rerun_cycles_clr", cycle_count, 0);
        adv(1);
        store(TOHOST, 32'hDEAD);
        check_eq("tohost_fail_status", status, 3);
        check_eq("tohost_fail_code", fail_code, 32'hDEAD);
        check_eq("tohost_fail_pass", pass, 0);

        // Boot PC mismatch
        restart(32'h0);
        adv(1);
        check_eq("boot_status", status, 3);
        check_eq("boot_fail_code", fail_code, 32'hB007_0BAD);

        // Console
        restart(32'h1000);
        adv(1);
        store(CONSOLE, 32'h141);
        check_eq("con_valid", console_valid, 1);
        check_eq("con_byte", console_byte, 8'h41);
        check_eq("con_stores", store_count, 1);
        check_eq("con_running", running, 1);
        adv(1);
        check_eq("con_valid_drop", console_valid, 0);
        check_eq("con_byte_held", console_byte, 8'h41);

        // Cycle watchdog
        restart(32'h1000);
        adv(49);
        check_eq("to_pre_status", status, 1);
        check_eq("to_pre_cycles", cycle_count, 49);
        adv(1);
        check_eq("to_status", status, 4);
        check_eq("to_cycles", cycle_count, 50);
        adv(2);
        check_eq("to_cycles_frozen", cycle_count, 50);

        // Stall watchdog
        restart(32'h1000);
        hold(7);
        check_eq("hang_pre_status", status, 1);
        hold(1);
        check_eq("hang_status", status, 5);
        check_eq("hang_cycles", cycle_count, 8);
        check_eq("hang_done", done, 1);

        // Tohost store on the timeout edge wins
        restart(32'h1000);
        adv(49);
        store(TOHOST, 32'h1);
        check_eq("prio_status", status, 2);
        check_eq("prio_cycles", cycle_count, 50);

        // Mid-run reset, then a clean run
        restart(32'h1000);
        adv(2);
        store(32'h2000, 32'h7);
        check_eq("mid_stores", store_count, 1);
        check_eq("mid_cycles", cycle_count, 3);
        #1;
        rst       = 1'b1;
        inst_addr = 32'h1000;
        #1;
        check_eq("mid_rst_status", status, 0);
        check_eq("mid_rst_cpu_rst", cpu_rst, 1);
        check_eq("mid_rst_cycles", cycle_count, 0);
        check_eq("mid_rst_stores", store_count, 0);
        #1;
        rst = 1'b0;
        hold(2);
        check_eq("rerun_running", running, 1);
        adv(2);
        store(TOHOST, 32'h1);
        check_eq("rerun_status", status, 2);
        check_eq("rerun_cycles", cycle_count, 3);
        check_eq("rerun_stores", store_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
